// File: rtl/division_if.sv
// Start/busy/done handshake and operand/result bundle for the divider.
// The controller drives the master side; the divider is the slave.
interface division_if #(
    parameter int WIDTH  = 4,
    parameter int DWIDTH = 2
);
    logic              start;
    logic [WIDTH-1:0]  dividend;
    logic [DWIDTH-1:0] divisor;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  quotient;
    logic [DWIDTH-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/division_unit.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results are held in output registers until the next accepted start.
module division_unit #(
    parameter int WIDTH  = 4,
    parameter int DWIDTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    division_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [DWIDTH-1:0] dvs_q, dvs_d;
    logic [DWIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  qout_q, qout_d;
    logic [DWIDTH-1:0] rout_q, rout_d;
    logic              dbz_q, dbz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DWIDTH:0]   r_ext;
    logic [DWIDTH-1:0] r_sub;
    logic [DWIDTH-1:0] r_next;
    logic [WIDTH-1:0]  q_next;
    logic              qbit;

    // One restoring step; the subtraction only needs DWIDTH bits since
    // whenever it is taken the true difference is below the divisor.
    always_comb begin
        r_ext  = {rem_q, dvd_q[WIDTH-1]};
        qbit   = (r_ext >= {1'b0, dvs_q});
        r_sub  = r_ext[DWIDTH-1:0] - dvs_q;
        r_next = qbit ? r_sub : r_ext[DWIDTH-1:0];
        q_next = {quo_q[WIDTH-2:0], qbit};
    end

    // Next-state and datapath update for IDLE/DIV/DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    dvd_d  = bus.dividend;
                    dvs_d  = bus.divisor;
                    rem_d  = '0;
                    quo_d  = '0;
                    qout_d = '0;
                    rout_d = '0;
                    dbz_d  = 1'b0;
                    if (bus.divisor != '0) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        qout_d  = '1;
                        dbz_d   = 1'b1;
                    end
                end
            end
            S_DIV: begin
                rem_d = r_next;
                quo_d = q_next;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    qout_d  = q_next;
                    rout_d  = r_next;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = qout_q;
    assign bus.remainder   = rout_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_division_unit.sv
// Directed and random checks of division_unit against integer division.
// Inputs change #1 after posedge or on negedge; outputs sampled on negedge.
module tb_division_unit;
    localparam int W  = 4;
    localparam int DW = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    division_if #(.WIDTH(W), .DWIDTH(DW)) dif ();

    division_unit #(.WIDTH(W), .DWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (dif.done === 1'b1) return;
            if (dif.busy === 1'b1) bcnt++;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int eq, er, ez;
        if (b == 0) begin
            eq = (1 << W) - 1;
            er = 0;
            ez = 1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 0;
        end
        check({tag, "_q"}, 32'(dif.quotient), 32'(eq));
        check({tag, "_r"}, 32'(dif.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(ez));
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        int cyc, bcnt;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = W'(a);
        dif.divisor  = DW'(b);
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        wait_done(cyc, bcnt);
        check({tag, "_lat"}, 32'(cyc), (b == 0) ? 32'd1 : 32'(W + 1));
        check({tag, "_busy"}, 32'(bcnt), (b == 0) ? 32'd0 : 32'(W));
        check_result(tag, a, b);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(dif.done), 32'd0);
        check_result({tag, "_hold"}, a, b);
    endtask

    initial begin
        int cyc, bcnt;
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        #1;
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_done", 32'(dif.done), 32'd0);
        check("rst_q", 32'(dif.quotient), 32'd0);
        check("rst_r", 32'(dif.remainder), 32'd0);
        check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("t1_9_2", 9, 2);
        run_op("t2_15_3", 15, 3);
        run_op("t2_2_3", 2, 3);
        run_op("t3_7_0", 7, 0);

        for (int a = 0; a < (1 << W); a++)
            for (int b = 1; b < (1 << DW); b++)
                run_op("sweep", a, b);

        for (int n = 0; n < 30; n++)
            run_op("rand", int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, (1 << DW) - 1)));

        // start during DIV cycle 2 must be ignored
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd9;
        dif.divisor  = 2'd2;
        @(posedge clk);
        #1 dif.start = 1'b0;
        @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = 4'd6;
        dif.divisor  = 2'd3;
        @(posedge clk);
        #1 dif.start = 1'b0;
        wait_done(cyc, bcnt);
        check("t4_lat", 32'(cyc), 32'(W - 1));
        check_result("t4", 9, 2);

        // async reset in DIV cycle 2
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd9;
        dif.divisor  = 2'd2;
        @(posedge clk);
        #1 dif.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(dif.busy), 32'd0);
        check("t5_done", 32'(dif.done), 32'd0);
        check("t5_q", 32'(dif.quotient), 32'd0);
        check("t5_r", 32'(dif.remainder), 32'd0);
        check("t5_dbz", 32'(dif.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5_6_3", 6, 3);

        // start held: back-to-back operations
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd12;
        dif.divisor  = 2'd2;
        wait_done(cyc, bcnt);
        check("t6a_lat", 32'(cyc), 32'(W + 1));
        check_result("t6a", 12, 2);
        dif.dividend = 4'd13;
        dif.divisor  = 2'd3;
        @(posedge clk);
        #1 dif.start = 1'b0;
        wait_done(cyc, bcnt);
        check("t6b_gap", 32'(cyc), 32'(W + 1));
        check_result("t6b", 13, 3);
        @(negedge clk);
        check("t6_pulse", 32'(dif.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
